// File: rtl/fc_layer_mac_seq.sv
// Sequential fully-connected layer: one signed MAC per cycle, weights/biases in
// internal RAM loaded over a config port, input vector streamed in, results
// streamed out with rescale, optional ReLU and saturation.
module fc_layer_mac_seq #(
    parameter int unsigned N_IN  = 10,
    parameter int unsigned N_OUT = 5,
    parameter int unsigned DW    = 8,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned RELU  = 0,
    localparam int unsigned AW   = $clog2(N_IN * N_OUT),
    localparam int unsigned OW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic                 cfg_sel,
    input  logic [AW-1:0]        cfg_addr,
    input  logic signed [DW-1:0] cfg_data,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic [OW-1:0]        out_idx,
    output logic                 out_last
);

    localparam int unsigned IW = $clog2(N_IN);
    localparam int unsigned PW = 2 * DW;
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [OW-1:0] J_LAST = OW'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Storage: not reset, contents survive reset and aborted vectors
    logic signed [DW-1:0] w_mem [N_IN*N_OUT];
    logic signed [DW-1:0] b_mem [N_OUT];
    logic signed [DW-1:0] x_mem [N_IN];

    state_t                  state_q, state_d;
    logic [IW-1:0]           i_q, i_d;
    logic [OW-1:0]           j_q, j_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [DW-1:0]    out_data_q, out_data_d;
    logic [OW-1:0]           out_idx_q, out_idx_d;
    logic                    out_last_q, out_last_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;

    logic [AW-1:0]           w_rd_addr;
    logic [OW-1:0]           b_rd_idx;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] relu_val;
    logic signed [DW-1:0]    sat_val;
    logic                    w_addr_ok;
    logic                    b_addr_ok;
    logic                    in_hs;

    assign in_hs     = in_valid && in_ready_q;
    assign w_addr_ok = ({1'b0, cfg_addr} < (AW+1)'(N_IN * N_OUT));
    assign b_addr_ok = ({1'b0, cfg_addr} < (AW+1)'(N_OUT));

    // Config writes (only while idle) and input element capture
    always_ff @(posedge clk) begin
        if (cfg_we && !busy_q) begin
            if (!cfg_sel && w_addr_ok) w_mem[cfg_addr] <= cfg_data;
            if (cfg_sel && b_addr_ok)  b_mem[OW'(cfg_addr)] <= cfg_data;
        end
        if (state_q == S_LOAD && in_hs) x_mem[i_q] <= in_data;
    end

    // MAC datapath: product, running sum, and bias preload for the next row
    always_comb begin
        w_rd_addr = AW'(j_q) * AW'(N_IN) + AW'(i_q);
        prod      = x_mem[i_q] * w_mem[w_rd_addr];
        mac_sum   = acc_q + ACC_W'(prod);
        b_rd_idx  = (state_q == S_OUT && j_q != J_LAST) ? OW'(j_q + OW'(1)) : '0;
        bias_ext  = ACC_W'(b_mem[b_rd_idx]) <<< SHIFT;
    end

    // Rescale (floor shift), optional ReLU, saturate to DW bits
    always_comb begin
        shifted  = mac_sum >>> SHIFT;
        relu_val = shifted;
        if (RELU != 0 && shifted[ACC_W-1]) relu_val = '0;
        if (relu_val > SAT_MAX)      sat_val = DW'(SAT_MAX);
        else if (relu_val < SAT_MIN) sat_val = DW'(SAT_MIN);
        else                         sat_val = DW'(relu_val);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            S_LOAD: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_hs) begin
                    if (i_q == I_LAST) begin
                        state_d    = S_MAC;
                        i_d        = '0;
                        j_d        = '0;
                        acc_d      = bias_ext;
                        in_ready_d = 1'b0;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
            end
            S_MAC: begin
                acc_d = mac_sum;
                if (i_q == I_LAST) begin
                    out_data_d  = sat_val;
                    out_idx_d   = j_q;
                    out_last_d  = (j_q == J_LAST);
                    out_valid_d = 1'b1;
                    i_d         = '0;
                    state_d     = S_OUT;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (j_q == J_LAST) begin
                        state_d    = S_LOAD;
                        j_d        = '0;
                        in_ready_d = 1'b1;
                    end else begin
                        j_d     = j_q + OW'(1);
                        acc_d   = bias_ext;
                        state_d = S_MAC;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        busy_d = (state_d != S_LOAD) || (i_d != '0);
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_fc_layer_mac_seq.sv
// Self-checking bench for fc_layer_mac_seq: three instances (plain, SHIFT=1,
// RELU=1) share stimulus and are compared against an arithmetic reference model.
module tb_fc_layer_mac_seq;

    localparam int N_IN  = 10;
    localparam int N_OUT = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic              cfg_sel;
    logic [5:0]        cfg_addr;
    logic signed [7:0] cfg_data;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              out_ready;

    logic              busy0, busy1, busy2;
    logic              in_ready0, in_ready1, in_ready2;
    logic              out_valid0, out_valid1, out_valid2;
    logic signed [7:0] out_data0, out_data1, out_data2;
    logic [2:0]        out_idx0, out_idx1, out_idx2;
    logic              out_last0, out_last1, out_last2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_last  = 0;

    // Reference state
    int w_m [N_OUT][N_IN];
    int b_m [N_OUT];
    int x_v [N_IN];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc_layer_mac_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(8), .ACC_W(24), .SHIFT(0), .RELU(0)) dut0 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .busy(busy0), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_idx(out_idx0), .out_last(out_last0));

    fc_layer_mac_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(8), .ACC_W(24), .SHIFT(1), .RELU(0)) dut1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .busy(busy1), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1));

    fc_layer_mac_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(8), .ACC_W(24), .SHIFT(0), .RELU(1)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .busy(busy2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2));

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // y[j] = sat(relu(floor((bias*2^sh + sum x*w) / 2^sh)))
    function automatic int model_y(input int j, input int sh, input int relu);
        int d;
        int s;
        int r;
        d = 1 << sh;
        s = b_m[j] * d;
        for (int i = 0; i < N_IN; i++) s += x_v[i] * w_m[j][i];
        if (s >= 0) r = s / d;
        else        r = -((-s + d - 1) / d);
        if (relu != 0 && r < 0) r = 0;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Issue one config write while idle; the model follows the address rules
    task automatic cfg_write(input logic sel, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = 6'(addr);
        cfg_data = 8'(data);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (!sel && addr < N_IN * N_OUT) w_m[addr / N_IN][addr % N_IN] = data;
        if (sel && addr < N_OUT) b_m[addr] = data;
    endtask

    task automatic load_all(input int mode);
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                case (mode)
                    0:       cfg_write(1'b0, j * N_IN + i, j + 1);
                    1:       cfg_write(1'b0, j * N_IN + i, 127);
                    2:       cfg_write(1'b0, j * N_IN + i, -128);
                    default: cfg_write(1'b0, j * N_IN + i, rnd8());
                endcase
            end
            cfg_write(1'b1, j, (mode >= 3) ? rnd8() : 0);
        end
    endtask

    // Stream x_v in; optionally pulse a W[0][0] write on beat wr_beat
    task automatic send_vec(input int wr_beat, input int wr_data);
        int n;
        for (int k = 0; k < N_IN; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(x_v[k]);
            n = 0;
            while (!in_ready0 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (!in_ready0) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
            if (k == wr_beat) begin
                check("busy_at_cfg", int'(busy0), (k != 0) ? 1 : 0);
                cfg_we   = 1'b1;
                cfg_sel  = 1'b0;
                cfg_addr = 6'd0;
                cfg_data = 8'(wr_data);
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
        end
        in_valid = 1'b0;
        t_last   = cyc;
        if (wr_beat == 0) w_m[0][0] = wr_data;
    endtask

    // Collect 'count' results; hold = cycles of backpressure, junk = noise on ignored inputs
    task automatic collect(input int count, input int hold, input bit junk);
        int n;
        int h;
        for (int j = 0; j < count; j++) begin
            n = 0;
            while (!out_valid0 && n < 200) begin
                if (junk) begin
                    in_valid  = 1'b1;
                    in_data   = 8'(rnd8());
                    out_ready = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
                n++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            if (!out_valid0) begin
                check("out_valid_timeout", 0, 1);
                return;
            end
            if (j == 0) check("first_latency", cyc - t_last, N_IN);
            check("out_valid_s1", int'(out_valid1), 1);
            check("out_valid_r1", int'(out_valid2), 1);
            check("out_idx", int'(out_idx0), j);
            check("out_last", int'(out_last0), (j == N_OUT - 1) ? 1 : 0);
            check("y_plain", int'(out_data0), model_y(j, 0, 0));
            check("y_shift1", int'(out_data1), model_y(j, 1, 0));
            check("y_relu", int'(out_data2), model_y(j, 0, 1));
            h = junk ? int'($urandom_range(0, 3)) : hold;
            for (int c = 0; c < h; c++) begin
                @(posedge clk); #1;
                if (!junk) begin
                    check("hold_valid", int'(out_valid0), 1);
                    check("hold_data", int'(out_data0), model_y(j, 0, 0));
                    check("hold_idx", int'(out_idx0), j);
                    check("hold_in_ready", int'(in_ready0), 0);
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("valid_drop", int'(out_valid0), 0);
            check("in_ready_after_hs", int'(in_ready0), (j == N_OUT - 1) ? 1 : 0);
        end
    endtask

    task automatic rand_x();
        for (int i = 0; i < N_IN; i++) x_v[i] = rnd8();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready0), 1);
        check({tag, "_out_valid"}, int'(out_valid0), 0);
        check({tag, "_out_data"}, int'(out_data0), 0);
        check({tag, "_out_idx"}, int'(out_idx0), 0);
        check({tag, "_out_last"}, int'(out_last0), 0);
        check({tag, "_busy"}, int'(busy0), 0);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic: x=1, W[j][i]=j+1, bias 0 -> 10..50
        load_all(0);
        for (int i = 0; i < N_IN; i++) x_v[i] = 1;
        send_vec(-1, 0);
        collect(N_OUT, 0, 1'b0);

        // Bias + floor shift on row 0
        for (int i = 0; i < N_IN; i++) cfg_write(1'b0, i, (i == 0) ? -3 : 0);
        cfg_write(1'b1, 0, 0);
        send_vec(-1, 0);
        collect(N_OUT, 0, 1'b0);
        cfg_write(1'b1, 0, 2);
        send_vec(-1, 0);
        collect(N_OUT, 0, 1'b0);

        // Saturation positive and negative
        load_all(1);
        for (int i = 0; i < N_IN; i++) x_v[i] = 127;
        send_vec(-1, 0);
        collect(N_OUT, 0, 1'b0);
        load_all(2);
        send_vec(-1, 0);
        collect(N_OUT, 0, 1'b0);

        // Backpressure: 7 stalled cycles per result
        load_all(3);
        rand_x();
        send_vec(-1, 0);
        collect(N_OUT, 7, 1'b0);

        // Config guard: write mid-vector ignored, write while idle applied
        rand_x();
        send_vec(3, 100);
        collect(N_OUT, 0, 1'b0);
        send_vec(-1, 0);
        collect(N_OUT, 0, 1'b0);
        cfg_write(1'b0, 0, 100);
        send_vec(-1, 0);
        collect(N_OUT, 0, 1'b0);
        send_vec(0, -77);
        collect(N_OUT, 0, 1'b0);

        // Out-of-range addresses are dropped
        cfg_write(1'b1, 8, 50);
        cfg_write(1'b1, 5, 50);
        cfg_write(1'b0, 63, 50);
        send_vec(-1, 0);
        collect(N_OUT, 0, 1'b0);

        // Reset during MAC of row 2, then a clean vector
        rand_x();
        send_vec(-1, 0);
        collect(2, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("busy_mid_mac", int'(busy0), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rand_x();
        send_vec(-1, 0);
        collect(N_OUT, 0, 1'b0);

        // Random weights/inputs with noise on ignored inputs and random stalls
        for (int v = 0; v < 4; v++) begin
            load_all(3);
            rand_x();
            send_vec(-1, 0);
            collect(N_OUT, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
